uart_rx_param: RTL

Parametrised UART receiver for the UART transfer path. It is the next generation of the 8N1 receiver: data width, parity, stop-bit count and oversampling ratio are configurable. Each sample point uses a three-sample majority vote, and the block reports parity errors, framing errors and line breaks. It consumes the shared baud-rate `s_tick` and delivers one parallel word per frame to the downstream FIFO or consumer.

---
 rtl/uart_rx_param_if.sv | 32 +++
 rtl/uart_rx_param.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: receive-side output bundle of the parametrised UART receiver.
//   dout         received word, LSB first on the line
//   rx_done_tick one-cycle pulse when dout and the flags update
//   parity_err   parity mismatch in the last frame
//   frame_err    a stop bit sampled low in the last frame
//   break_det    last frame was all-zero, including parity and stop bits
// master: the receiver driving the bundle; slave: the downstream consumer.
interface uart_rx_param_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] dout;
  logic                 rx_done_tick;
  logic                 parity_err;
  logic                 frame_err;
  logic                 break_det;

  modport master (
    output dout,
    output rx_done_tick,
    output parity_err,
    output frame_err,
    output break_det
  );

  modport slave (
    input dout,
    input rx_done_tick,
    input parity_err,
    input frame_err,
    input break_det
  );
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with majority-vote sampling.
//   clk     system clock
//   reset   asynchronous, active-high reset
//   s_tick  oversampling strobe, one clk wide, OVERSAMPLE pulses per bit
//   rx      asynchronous serial line, idle high
//   rx_out  word and status bundle (dout, rx_done_tick, parity_err, frame_err, break_det)
// Each bit is sampled at the three ticks around mid-bit and resolved by majority vote.
// The final stop bit ends the frame at mid-bit so IDLE re-arms half a bit early.
module uart_rx_param #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  uart_rx_param_if.master rx_out
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam int unsigned Half = OVERSAMPLE / 2;

  localparam logic [CntW-1:0] CntPre  = CntW'(Half - 1);
  localparam logic [CntW-1:0] CntMid  = CntW'(Half);
  localparam logic [CntW-1:0] CntRes  = CntW'(Half + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);
  localparam logic            StopLast = 1'(STOP_BITS - 1);
  localparam logic            ParEn    = (PARITY_EN != 0);
  localparam logic            ParOdd   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBrkWait
  } state_e;

  // Synchroniser
  logic rx_meta_q;
  logic rx_s_q;

  // Frame datapath and control
  state_e               state_q;
  logic [CntW-1:0]      cnt_q;
  logic [IdxW-1:0]      idx_q;
  logic                 stop_idx_q;
  logic [1:0]           samp_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 par_bit_q;
  logic                 ferr_pend_q;
  logic                 stop_low_q;

  // Registered outputs
  logic [DATA_BITS-1:0] dout_q;
  logic                 done_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 brk_q;

  logic maj;
  logic frame_perr;
  logic frame_ferr;
  logic frame_brk;

  // Resets to the idle level so a reset release never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // The third vote is the live synchronised sample at the resolve tick.
  always_comb begin
    maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
  end

  // Frame-end results; only consumed on the resolve tick of the final stop bit.
  always_comb begin
    frame_perr = ParEn & ((^shreg_q ^ par_bit_q) != ParOdd);
    frame_ferr = ferr_pend_q | ~maj;
    // par_bit_q stays 0 when parity is disabled.
    frame_brk  = (shreg_q == '0) & ~par_bit_q & stop_low_q & ~maj;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      stop_idx_q  <= 1'b0;
      samp_q      <= '0;
      shreg_q     <= '0;
      par_bit_q   <= 1'b0;
      ferr_pend_q <= 1'b0;
      stop_low_q  <= 1'b0;
      dout_q      <= '0;
      done_q      <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (s_tick) begin
        if (cnt_q == CntPre) samp_q[0] <= rx_s_q;
        if (cnt_q == CntMid) samp_q[1] <= rx_s_q;
        unique case (state_q)
          StIdle: begin
            if (!rx_s_q) begin
              state_q     <= StStart;
              cnt_q       <= '0;
              par_bit_q   <= 1'b0;
              ferr_pend_q <= 1'b0;
              stop_low_q  <= 1'b1;
            end
          end
          StStart: begin
            if (cnt_q == CntRes && maj) begin
              // Line back high at mid start bit: treat as a glitch.
              state_q <= StIdle;
            end else if (cnt_q == CntLast) begin
              state_q <= StData;
              cnt_q   <= '0;
              idx_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StData: begin
            if (cnt_q == CntRes) shreg_q <= {maj, shreg_q[DATA_BITS-1:1]};
            if (cnt_q == CntLast) begin
              cnt_q <= '0;
              if (idx_q == IdxLast) begin
                state_q    <= ParEn ? StParity : StStop;
                stop_idx_q <= 1'b0;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StParity: begin
            if (cnt_q == CntRes) par_bit_q <= maj;
            if (cnt_q == CntLast) begin
              state_q    <= StStop;
              stop_idx_q <= 1'b0;
              cnt_q      <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StStop: begin
            if (cnt_q == CntRes && stop_idx_q == StopLast) begin
              dout_q  <= shreg_q;
              perr_q  <= frame_perr;
              ferr_q  <= frame_ferr;
              brk_q   <= frame_brk;
              done_q  <= 1'b1;
              cnt_q   <= '0;
              // A low stop bit may be a held line; wait for it to go high first.
              state_q <= frame_ferr ? StBrkWait : StIdle;
            end else begin
              if (cnt_q == CntRes) begin
                ferr_pend_q <= ferr_pend_q | ~maj;
                stop_low_q  <= stop_low_q & ~maj;
              end
              if (cnt_q == CntLast) begin
                cnt_q      <= '0;
                stop_idx_q <= stop_idx_q + 1'b1;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          StBrkWait: begin
            if (rx_s_q) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign rx_out.dout         = dout_q;
  assign rx_out.rx_done_tick = done_q;
  assign rx_out.parity_err   = perr_q;
  assign rx_out.frame_err    = ferr_q;
  assign rx_out.break_det    = brk_q;

endmodule
